// File: rtl/msi_tx_pkg.sv
// Shared constants, access decode and STATUS word packing for the MSI transmitter.
package msi_tx_pkg;

    localparam int HOST_AW = 4;
    localparam int HOST_DW = 32;

    localparam logic [HOST_AW-1:0] CODE_ADDR   = 4'h0;
    localparam logic [HOST_AW-1:0] STATUS_ADDR = 4'h4;

    localparam int OVF_BIT   = 31;
    localparam int FULL_BIT  = 16;
    localparam int COUNT_LSB = 0;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_CODE_WR,
        ACC_STAT_WR,
        ACC_STAT_RD,
        ACC_ZERO_RD
    } access_e;

    function automatic access_e decode_access(logic req, logic we, logic [HOST_AW-1:0] addr);
        if (!req) return ACC_NONE;
        if (we) begin
            if (addr == CODE_ADDR)   return ACC_CODE_WR;
            if (addr == STATUS_ADDR) return ACC_STAT_WR;
            return ACC_NONE;
        end
        if (addr == STATUS_ADDR) return ACC_STAT_RD;
        return ACC_ZERO_RD;
    endfunction

    function automatic logic [HOST_DW-1:0] pack_status(logic ovf, logic full, logic [15:0] count);
        logic [HOST_DW-1:0] s;
        s                  = '0;
        s[OVF_BIT]         = ovf;
        s[FULL_BIT]        = full;
        s[COUNT_LSB +: 16] = count;
        return s;
    endfunction

endpackage

// File: rtl/msi_transmitter_if.sv
// Host-side register bus of the MSI transmitter.
interface msi_transmitter_if;
    // A request is taken in the same cycle it is raised (ack mirrors req); a read
    // returns its data with a one-cycle resp pulse in the following cycle.
    logic        host_req;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic        host_resp;
    logic [31:0] host_rdata;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_resp, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_resp, host_rdata
    );
endinterface

// File: rtl/msi_tx_fifo.sv
// Synchronous FIFO with wrapping pointers and an occupancy count one bit wider than the pointers.
module msi_tx_fifo #(
    parameter int WIDTH     = 4,
    parameter int DEPTH_POW = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [DEPTH_POW:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam int DEPTH = 1 << DEPTH_POW;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_POW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_POW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_POW:0]   count_q, count_d;
    logic                 do_push, do_pop;

    // Count never exceeds DEPTH, so its top bit alone marks full.
    assign full_o  = count_q[DEPTH_POW];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_POW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_POW'(1);
        if (do_push && !do_pop) count_d = count_q + (DEPTH_POW+1)'(1);
        if (!do_push && do_pop) count_d = count_q - (DEPTH_POW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/msi_transmitter.sv
// MSI source: host-written codes are queued and sent as spaced single-cycle pulses.
// Define MSI_TX_COALESCE_EN to drop CODE writes whose code is already queued.
module msi_transmitter
    import msi_tx_pkg::*;
#(
    parameter int IRQ_NUM_POW    = 4,
    parameter int FIFO_DEPTH_POW = 2,
    parameter int MIN_GAP        = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    msi_transmitter_if.slave       host_io,
    output logic                   msi_req_o,
    output logic [IRQ_NUM_POW-1:0] msi_code_bo
);
    localparam int         CNT_W    = FIFO_DEPTH_POW + 1;
    localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP);

    access_e                acc;
    logic [IRQ_NUM_POW-1:0] code_w;
    logic [IRQ_NUM_POW-1:0] head;
    logic [CNT_W-1:0]       fifo_count, count_nx;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop, dup, ovf_set;
    logic                   wdata_unused;

    logic                   ovf_q, ovf_d;
    logic [7:0]             gap_q, gap_d;
    logic                   resp_q, resp_d;
    logic [HOST_DW-1:0]     rdata_q, rdata_d;
    logic                   msi_req_q, msi_req_d;
    logic [IRQ_NUM_POW-1:0] msi_code_q, msi_code_d;

    assign acc          = decode_access(host_io.host_req, host_io.host_we, host_io.host_addr);
    assign code_w       = host_io.host_wdata[IRQ_NUM_POW-1:0];
    assign wdata_unused = ^host_io.host_wdata;
    assign host_io.host_ack = host_io.host_req;

    assign pop     = !fifo_empty && (gap_q == 8'd0);
    // Fullness comes from the count at the start of the cycle, so a same-cycle pop never frees a slot.
    assign push    = (acc == ACC_CODE_WR) && !fifo_full && !dup;
    assign ovf_set = (acc == ACC_CODE_WR) && fifo_full && !dup;

`ifdef MSI_TX_COALESCE_EN
    logic [2**IRQ_NUM_POW-1:0] pend_q, pend_d;

    // A code leaving the queue this cycle no longer counts as pending for a new write of it.
    assign dup = pend_q[code_w] && !(pop && (head == code_w));

    always_comb begin
        pend_d = pend_q;
        if (pop)  pend_d[head]   = 1'b0;
        if (push) pend_d[code_w] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) pend_q <= '0;
        else        pend_q <= pend_d;
    end
`else
    assign dup = 1'b0;
`endif

    msi_tx_fifo #(
        .WIDTH     (IRQ_NUM_POW),
        .DEPTH_POW (FIFO_DEPTH_POW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (code_w),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        count_nx = fifo_count;
        if (push && !pop) count_nx = fifo_count + CNT_W'(1);
        if (!push && pop) count_nx = fifo_count - CNT_W'(1);
    end

    always_comb begin
        ovf_d = ovf_q;
        if (acc == ACC_STAT_WR && host_io.host_wdata[OVF_BIT]) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;

        gap_d = gap_q;
        if (pop)                 gap_d = GAP_LOAD;
        else if (gap_q != 8'd0)  gap_d = gap_q - 8'd1;

        // STATUS reads report the state as it stands at the end of the access cycle.
        resp_d  = (acc == ACC_STAT_RD) || (acc == ACC_ZERO_RD);
        rdata_d = '0;
        if (acc == ACC_STAT_RD) rdata_d = pack_status(ovf_d, count_nx[FIFO_DEPTH_POW], 16'(count_nx));

        msi_req_d  = pop;
        msi_code_d = pop ? head : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q      <= 1'b0;
            gap_q      <= 8'd0;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
            msi_req_q  <= 1'b0;
            msi_code_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            gap_q      <= gap_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            msi_req_q  <= msi_req_d;
            msi_code_q <= msi_code_d;
        end
    end

    assign host_io.host_resp  = resp_q;
    assign host_io.host_rdata = rdata_q;
    assign msi_req_o          = msi_req_q;
    assign msi_code_bo        = msi_code_q;
endmodule

// File: tb/tb_msi_transmitter.sv
// Directed bench for msi_transmitter: three instances with MIN_GAP 0, 2 and 8 share clock and reset.
module tb_msi_transmitter;
    import msi_tx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req   [3];
    logic        we    [3];
    logic [3:0]  addr  [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic        resp  [3];
    logic [31:0] rdata [3];
    logic        msi_req  [3];
    logic [3:0]  msi_code [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int GAP = (g == 0) ? 0 : ((g == 1) ? 2 : 8);
            msi_transmitter_if bus ();
            assign bus.host_req   = req[g];
            assign bus.host_we    = we[g];
            assign bus.host_addr  = addr[g];
            assign bus.host_wdata = wdata[g];
            assign ack[g]   = bus.host_ack;
            assign resp[g]  = bus.host_resp;
            assign rdata[g] = bus.host_rdata;
            msi_transmitter #(
                .IRQ_NUM_POW    (4),
                .FIFO_DEPTH_POW (2),
                .MIN_GAP        (GAP)
            ) dut (
                .clk_i       (clk),
                .rst_i       (rst_n),
                .host_io     (bus),
                .msi_req_o   (msi_req[g]),
                .msi_code_bo (msi_code[g])
            );
        end
    endgenerate

    int errors = 0;
    int checks = 0;
    int mon_bad = 0;
    int n;

    // Pulse records are {instance, cycle, code}.
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] pk(logic [1:0] g, logic [25:0] c, logic [3:0] code);
        return {g, c, code};
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (msi_req[g]) obs_q.push_back(pk(g[1:0], cyc[25:0], msi_code[g]));
            else if (msi_code[g] != 4'd0) mon_bad++;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_pulses(string name);
        chk({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_%0d", name, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic drive(int g, logic we_v, logic [3:0] a, logic [31:0] d);
        @(posedge clk);
        #1;
        req[g]   = 1'b1;
        we[g]    = we_v;
        addr[g]  = a;
        wdata[g] = d;
        #1;
        chk("ack", 32'(ack[g]), 32'd1);
    endtask

    task automatic idle(int g);
        @(posedge clk);
        #1;
        req[g] = 1'b0;
        we[g]  = 1'b0;
    endtask

    task automatic read_status(int g, logic [31:0] exp, string name);
        drive(g, 1'b0, STATUS_ADDR, 32'd0);
        idle(g);
        @(negedge clk);
        chk({name, "_resp"}, 32'(resp[g]), 32'd1);
        chk(name, rdata[g], exp);
    endtask

    task automatic chk_quiet(int g, string name);
        chk({name, "_resp"},  32'(resp[g]), 32'd0);
        chk({name, "_rdata"}, rdata[g], 32'd0);
        chk({name, "_req"},   32'(msi_req[g]), 32'd0);
        chk({name, "_code"},  32'(msi_code[g]), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 4'h4, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[1] = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b0, 4'h8, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b1, 4'h8, 32'h0000_0005, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 4'h2, 32'h0000_0007, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b0, 4'h4, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[6] = '{1'b1, 4'h4, 32'h8000_0000, 1'b0, 32'h0000_0000};
        vecs[7] = '{1'b0, 4'hC, 32'h0000_0000, 1'b1, 32'h0000_0000};

        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            req[g] = 1'b0; we[g] = 1'b0; addr[g] = 4'h0; wdata[g] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) chk_quiet(g, $sformatf("reset_g%0d", g));
        rst_n = 1'b1;
        @(posedge clk);

        // Register access vectors against the MIN_GAP=0 instance.
        for (int i = 0; i < 8; i++) begin
            drive(0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            idle(0);
            @(negedge clk);
            chk($sformatf("vec%0d_resp", i), 32'(resp[0]), 32'(vecs[i].exp_resp));
            if (vecs[i].exp_resp) chk($sformatf("vec%0d_rdata", i), rdata[0], vecs[i].exp_rdata);
        end
        check_pulses("no_pulse_oor");

        // Single send: pulse exactly at N+2.
        drive(0, 1'b1, CODE_ADDR, 32'h0000_0005);
        n = cyc;
        idle(0);
        repeat (5) @(posedge clk);
        exp_q.push_back(pk(2'd0, 26'(n + 2), 4'd5));
        check_pulses("single");
        read_status(0, 32'h0000_0000, "single_status");

        // Spacing with MIN_GAP=2.
        drive(1, 1'b1, CODE_ADDR, 32'h0000_0003);
        n = cyc;
        drive(1, 1'b1, CODE_ADDR, 32'h0000_0007);
        drive(1, 1'b1, CODE_ADDR, 32'h0000_0009);
        idle(1);
        repeat (12) @(posedge clk);
        exp_q.push_back(pk(2'd1, 26'(n + 2), 4'd3));
        exp_q.push_back(pk(2'd1, 26'(n + 5), 4'd7));
        exp_q.push_back(pk(2'd1, 26'(n + 8), 4'd9));
        check_pulses("spacing");

        // Overflow and clear with MIN_GAP=8, depth 4.
        drive(2, 1'b1, CODE_ADDR, 32'h0000_0001);
        n = cyc;
        for (int c = 2; c <= 6; c++) drive(2, 1'b1, CODE_ADDR, 32'(c));
        idle(2);
        read_status(2, 32'h8001_0004, "ovf_status");
        drive(2, 1'b1, STATUS_ADDR, 32'h8000_0000);
        idle(2);
        read_status(2, 32'h0000_0003, "ovf_cleared");
        repeat (40) @(posedge clk);
        for (int c = 1; c <= 5; c++) exp_q.push_back(pk(2'd2, 26'(n + 2 + 9 * (c - 1)), 4'(c)));
        check_pulses("ovf_drain");

        // Duplicate code while the first copy is still queued.
        drive(2, 1'b1, CODE_ADDR, 32'h0000_0001);
        n = cyc;
        drive(2, 1'b1, CODE_ADDR, 32'h0000_0003);
        drive(2, 1'b1, CODE_ADDR, 32'h0000_0003);
        idle(2);
`ifdef MSI_TX_COALESCE_EN
        read_status(2, 32'h0000_0001, "coal_status");
`else
        read_status(2, 32'h0000_0002, "coal_status");
`endif
        repeat (30) @(posedge clk);
        exp_q.push_back(pk(2'd2, 26'(n + 2), 4'd1));
        exp_q.push_back(pk(2'd2, 26'(n + 11), 4'd3));
`ifndef MSI_TX_COALESCE_EN
        exp_q.push_back(pk(2'd2, 26'(n + 20), 4'd3));
`endif
        check_pulses("coalesce");

        // Reset while three codes are pending.
        drive(2, 1'b1, CODE_ADDR, 32'h0000_0001);
        n = cyc;
        drive(2, 1'b1, CODE_ADDR, 32'h0000_0004);
        drive(2, 1'b1, CODE_ADDR, 32'h0000_0005);
        drive(2, 1'b1, CODE_ADDR, 32'h0000_0006);
        idle(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_quiet(2, "midreset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        exp_q.push_back(pk(2'd2, 26'(n + 2), 4'd1));
        check_pulses("reset_drop");
        read_status(2, 32'h0000_0000, "reset_status");

        chk("code_zero_when_idle", 32'(mon_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
